// File: rtl/mesh_torus_cfg_loader_pkg.sv
// Shared NoC helpers: width derivation, loader state encoding, id/address maps.
package mesh_torus_cfg_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  // Index width with a floor of one bit so degenerate dimensions still get a port.
  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

  // Linear router id: y*NX + x.
  function automatic int unsigned router_id(input int unsigned x, input int unsigned y,
                                            input int unsigned nx);
    return y * nx + x;
  endfunction

  // Packed router address: y in the upper field, x in the lower NXw bits.
  function automatic int unsigned router_addr(input int unsigned x, input int unsigned y,
                                              input int unsigned nxw);
    return (y << nxw) + x;
  endfunction

  // Linear endpoint id: router_id*NL + l.
  function automatic int unsigned endp_id(input int unsigned rid, input int unsigned l,
                                          input int unsigned nl);
    return rid * nl + l;
  endfunction

  // Endpoint address: local index concatenated above the router address.
  function automatic int unsigned endp_addr(input int unsigned l, input int unsigned raddr,
                                            input int unsigned raw);
    return (l << raw) | raddr;
  endfunction

endpackage

// File: rtl/mesh_torus_cfg_counter.sv
// l/x/y nested wrap counter; l is fastest, carry into x, then y.
module mesh_torus_cfg_counter
  import mesh_torus_cfg_loader_pkg::*;
#(
  parameter int unsigned NX = 4,
  parameter int unsigned NY = 4,
  parameter int unsigned NL = 1,
  localparam int unsigned NXw = idx_w(NX),
  localparam int unsigned NYw = idx_w(NY),
  localparam int unsigned NLw = idx_w(NL)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [NXw-1:0] x_next_c,
  output logic [NYw-1:0] y_next_c,
  output logic [NLw-1:0] l_next_c,
  output logic           last_c,
  output logic           last_next_c
);

  localparam logic [NXw-1:0] X_MAX = NXw'(NX - 1);
  localparam logic [NYw-1:0] Y_MAX = NYw'(NY - 1);
  localparam logic [NLw-1:0] L_MAX = NLw'(NL - 1);

  logic [NXw-1:0] x;
  logic [NYw-1:0] y;
  logic [NLw-1:0] l;

  // Next position: clear wins, otherwise step with carry on advance.
  always_comb begin
    x_next_c = x;
    y_next_c = y;
    l_next_c = l;
    if (clear) begin
      x_next_c = '0;
      y_next_c = '0;
      l_next_c = '0;
    end else if (advance) begin
      if (l == L_MAX) begin
        l_next_c = '0;
        if (x == X_MAX) begin
          x_next_c = '0;
          y_next_c = (y == Y_MAX) ? '0 : y + NYw'(1);
        end else begin
          x_next_c = x + NXw'(1);
        end
      end else begin
        l_next_c = l + NLw'(1);
      end
    end
    last_c      = (l == L_MAX) && (x == X_MAX) && (y == Y_MAX);
    last_next_c = (l_next_c == L_MAX) && (x_next_c == X_MAX) && (y_next_c == Y_MAX);
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
      l <= '0;
    end else begin
      x <= x_next_c;
      y <= y_next_c;
      l <= l_next_c;
    end
  end

endmodule

// File: rtl/mesh_torus_cfg_loader.sv
// Walks every router/endpoint of the mesh and emits one valid/ready config beat each.
module mesh_torus_cfg_loader
  import mesh_torus_cfg_loader_pkg::*;
#(
  parameter int unsigned NX      = 4,
  parameter int unsigned NY      = 4,
  parameter int unsigned NL      = 1,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned NXw = idx_w(NX),
  localparam int unsigned NYw = idx_w(NY),
  localparam int unsigned NLw = idx_w(NL),
  localparam int unsigned RAw = NXw + NYw,
  localparam int unsigned NRw = idx_w(NX * NY),
  localparam int unsigned EAw = RAw + NLw,
  localparam int unsigned NEw = idx_w(NX * NY * NL)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           cfg_valid,
  input  logic           cfg_ready,
  output logic [NRw-1:0] cfg_router_id,
  output logic [RAw-1:0] cfg_router_addr,
  output logic [NLw-1:0] cfg_local,
  output logic [NEw-1:0] cfg_endp_id,
  output logic [EAw-1:0] cfg_endp_addr,
  output logic           cfg_last,
  output logic           busy,
  output logic           done,
  output logic           error
);

  localparam int unsigned    WCw       = idx_w(TIMEOUT + 1);
  localparam logic [WCw-1:0] WAIT_SAT  = WCw'(TIMEOUT);

  state_t         state, state_next;
  logic [WCw-1:0] wait_cnt, wait_next;
  logic           clear, advance;
  logic [NXw-1:0] x_next;
  logic [NYw-1:0] y_next;
  logic [NLw-1:0] l_next;
  logic           last_cur, last_next;
  logic [NRw-1:0] rid_next;
  logic [RAw-1:0] raddr_next;
  logic [NEw-1:0] eid_next;
  logic [EAw-1:0] eaddr_next;

  mesh_torus_cfg_counter #(
    .NX (NX),
    .NY (NY),
    .NL (NL)
  ) u_counter (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .advance     (advance),
    .x_next_c    (x_next),
    .y_next_c    (y_next),
    .l_next_c    (l_next),
    .last_c      (last_cur),
    .last_next_c (last_next)
  );

  // Fields of the beat that will be presented next cycle, truncated to port widths.
  assign rid_next   = NRw'(router_id(32'(x_next), 32'(y_next), NX));
  assign raddr_next = RAw'(router_addr(32'(x_next), 32'(y_next), NXw));
  assign eid_next   = NEw'(endp_id(router_id(32'(x_next), 32'(y_next), NX), 32'(l_next), NL));
  assign eaddr_next = EAw'(endp_addr(32'(l_next), 32'(raddr_next), RAw));

  // State and handshake wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Next state, counter control and wait tracking; start is only honoured outside LOAD.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    clear      = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_LOAD: begin
        if (cfg_ready) begin
          advance   = 1'b1;
          wait_next = '0;
          if (last_cur) state_next = ST_DONE;
        end else if (wait_cnt == WAIT_SAT) begin
          state_next = ST_ERROR;
        end else begin
          wait_next = wait_cnt + WCw'(1);
        end
      end
      default: begin
        if (start) begin
          state_next = ST_LOAD;
          clear      = 1'b1;
          wait_next  = '0;
        end
      end
    endcase
  end

  // Registered beat and status outputs, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_valid       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      cfg_last        <= 1'b0;
      cfg_router_id   <= '0;
      cfg_router_addr <= '0;
      cfg_local       <= '0;
      cfg_endp_id     <= '0;
      cfg_endp_addr   <= '0;
    end else begin
      cfg_valid       <= (state_next == ST_LOAD);
      busy            <= (state_next == ST_LOAD);
      done            <= (state_next == ST_DONE);
      error           <= (state_next == ST_ERROR);
      cfg_last        <= (state_next == ST_LOAD) && last_next;
      cfg_router_id   <= rid_next;
      cfg_router_addr <= raddr_next;
      cfg_local       <= l_next;
      cfg_endp_id     <= eid_next;
      cfg_endp_addr   <= eaddr_next;
    end
  end

endmodule

// File: tb/tb_mesh_torus_cfg_loader.sv
// Bench for the mesh config loader: beat-index reference model, per-cycle compare, literal pins.
module tb_mesh_torus_cfg_loader;

  localparam int unsigned NX      = 4;
  localparam int unsigned NY      = 2;
  localparam int unsigned NL      = 2;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned TOTAL   = NX * NY * NL;
  localparam int unsigned NXW     = 2;
  localparam int unsigned RAW     = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cfg_ready = 1'b0;
  logic       cfg_valid;
  logic [2:0] cfg_router_id;
  logic [2:0] cfg_router_addr;
  logic [0:0] cfg_local;
  logic [3:0] cfg_endp_id;
  logic [3:0] cfg_endp_addr;
  logic       cfg_last, busy, done, error;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  mesh_torus_cfg_loader #(
    .NX (NX), .NY (NY), .NL (NL), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_router_id   (cfg_router_id),
    .cfg_router_addr (cfg_router_addr),
    .cfg_local       (cfg_local),
    .cfg_endp_id     (cfg_endp_id),
    .cfg_endp_addr   (cfg_endp_addr),
    .cfg_last        (cfg_last),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 load, 2 done, 3 error; k is the beat index in the run.
  int m_mode  = 0;
  int m_k     = 0;
  int m_wait  = 0;
  bit m_fresh = 1'b1;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_k = 0; m_wait = 0; m_fresh = 1'b1;
    end else if (m_mode == 1) begin
      if (cfg_ready) begin
        m_wait = 0;
        if (m_k == int'(TOTAL) - 1) m_mode = 2;
        else m_k++;
      end else if (m_wait == int'(TIMEOUT)) begin
        m_mode = 3;
      end else begin
        m_wait++;
      end
    end else if (start) begin
      m_mode = 1; m_k = 0; m_wait = 0; m_fresh = 1'b0;
    end
  end

  // Per-cycle compare of every output against the model.
  int el, ex, ey, erid, eraddr;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(cfg_valid), 32'(m_mode == 1));
      chk("busy",  32'(busy),      32'(m_mode == 1));
      chk("done",  32'(done),      32'(m_mode == 2));
      chk("error", 32'(error),     32'(m_mode == 3));
      if (m_mode == 1) begin
        el     = m_k % int'(NL);
        ex     = (m_k / int'(NL)) % int'(NX);
        ey     = m_k / int'(NL * NX);
        erid   = ey * int'(NX) + ex;
        eraddr = ey * (1 << NXW) + ex;
        chk("router_id",   32'(cfg_router_id),   32'(erid));
        chk("router_addr", 32'(cfg_router_addr), 32'(eraddr));
        chk("local",       32'(cfg_local),       32'(el));
        chk("endp_id",     32'(cfg_endp_id),     32'(erid * int'(NL) + el));
        chk("endp_addr",   32'(cfg_endp_addr),   32'(el * (1 << RAW) + eraddr));
        chk("last",        32'(cfg_last),        32'(m_k == int'(TOTAL) - 1));
      end else begin
        chk("last_idle", 32'(cfg_last), 0);
        if (m_fresh) begin
          chk("reset_router_id", 32'(cfg_router_id),   0);
          chk("reset_raddr",     32'(cfg_router_addr), 0);
          chk("reset_local",     32'(cfg_local),       0);
          chk("reset_endp_id",   32'(cfg_endp_id),     0);
          chk("reset_endp_addr", 32'(cfg_endp_addr),   0);
        end
      end
    end
  end

  // Transfer counter per run; checked when done rises.
  int obs = 0;
  bit done_d = 1'b0;
  always @(negedge clk) begin
    if (chk_en && done && !done_d) chk("beat_count", 32'(obs), TOTAL);
    done_d = done;
    if (!cfg_valid) obs = 0;
    else if (cfg_ready) obs++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic finish_run(input string nm);
    int n;
    n = 0;
    cfg_ready = 1'b1;
    while (!done && n < 100) begin
      cyc(1);
      n++;
    end
    chk(nm, 32'(done), 1);
  endtask

  int unsigned ra[TOTAL];
  int unsigned ea[TOTAL];
  int unsigned ri[TOTAL];
  int unsigned ls[TOTAL];
  int unsigned vall;
  int low, n;

  initial begin
    // Reset, with a start that must be ignored alongside it.
    reset = 1'b1; start = 1'b1;
    cyc(1);
    chk_en = 1'b1;
    start = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    chk("idle_after_reset", 32'(cfg_valid), 0);

    // Back-to-back run with ready held high: beats on cycles 1..TOTAL, done after.
    cfg_ready = 1'b1;
    pulse_start();
    vall = 1;
    for (int i = 0; i < int'(TOTAL); i++) begin
      ra[i] = 32'(cfg_router_addr);
      ea[i] = 32'(cfg_endp_addr);
      ri[i] = 32'(cfg_router_id);
      ls[i] = 32'(cfg_last);
      vall  = vall & 32'(cfg_valid);
      cyc(1);
    end
    chk("lit_all_valid",  vall, 1);
    chk("lit_done_cycle", 32'(done), 1);
    chk("lit_valid_off",  32'(cfg_valid), 0);
    chk("lit_eaddr_b2",   ea[1], 8);
    chk("lit_eaddr_b6",   ea[5], 10);
    chk("lit_rid_b9",     ri[8], 4);
    chk("lit_raddr_b9",   ra[8], 4);
    chk("lit_raddr_b16",  ra[15], 7);
    chk("lit_eaddr_b16",  ea[15], 15);
    chk("lit_last_b15",   ls[14], 0);
    chk("lit_last_b16",   ls[15], 1);
    cyc(2);

    // Stall at beat 5 for three cycles: fields held, no error.
    pulse_start();
    cyc(4);
    chk("stall_pre", 32'(cfg_endp_id), 4);
    cfg_ready = 1'b0;
    cyc(3);
    chk("stall_hold", 32'(cfg_endp_id), 4);
    chk("stall_noerr", 32'(error), 0);
    cfg_ready = 1'b1;
    cyc(1);
    chk("stall_next", 32'(cfg_endp_id), 5);
    finish_run("stall_run_done");
    cyc(2);

    // Ready returns exactly when the wait counter saturates: accepted.
    cfg_ready = 1'b0;
    pulse_start();
    cyc(4);
    cfg_ready = 1'b1;
    cyc(1);
    chk("edge_noerr", 32'(error), 0);
    chk("edge_valid", 32'(cfg_valid), 1);
    chk("edge_endp",  32'(cfg_endp_id), 1);
    finish_run("edge_run_done");
    cyc(2);

    // Ready never comes: error five cycles after the first valid, held until start.
    cfg_ready = 1'b0;
    pulse_start();
    cyc(4);
    chk("to_still_valid", 32'(cfg_valid), 1);
    chk("to_not_yet",     32'(error), 0);
    cyc(1);
    chk("to_error",       32'(error), 1);
    chk("to_valid_off",   32'(cfg_valid), 0);
    cyc(3);
    chk("to_error_held",  32'(error), 1);
    cfg_ready = 1'b1;
    pulse_start();
    chk("to_restart_id",  32'(cfg_endp_id), 0);
    chk("to_restart_err", 32'(error), 0);
    finish_run("to_restart_done");
    cyc(2);

    // Reset during beat 7, then a fresh run starts from router 0.
    cfg_ready = 1'b1;
    pulse_start();
    cyc(6);
    chk("rst_beat7", 32'(cfg_endp_id), 6);
    reset = 1'b1;
    cyc(1);
    chk("rst_valid", 32'(cfg_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_eid",   32'(cfg_endp_id), 0);
    reset = 1'b0;
    cyc(2);
    pulse_start();
    chk("rst_restart_rid", 32'(cfg_router_id), 0);
    chk("rst_restart_vld", 32'(cfg_valid), 1);
    finish_run("rst_run_done");
    cyc(2);

    // Randomized ready with stray start pulses during LOAD.
    for (int r = 0; r < 8; r++) begin
      cfg_ready = 1'($urandom_range(0, 1));
      pulse_start();
      low = 0;
      n = 0;
      while (m_mode == 1 && n < 300) begin
        if (low >= 3) cfg_ready = 1'b1;
        else cfg_ready = ($urandom_range(0, 2) != 0);
        low = cfg_ready ? 0 : low + 1;
        start = ($urandom_range(0, 9) == 0);
        cyc(1);
        n++;
      end
      start = 1'b0;
      cfg_ready = 1'b0;
      chk("rand_run_done", 32'(done), 1);
      cyc($urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
